// File: rtl/sonar_mmio_array.sv
`default_nettype none
// ============================================================================
// Module   : sonar_mmio_array
// Brief    : Memory-mapped multi-channel ultrasonic ranging peripheral with
//            per-channel trigger/echo FSMs, timeout and result registers.
// Revision : 1.0 - initial release
// ============================================================================
module sonar_mmio_array #(
    parameter int                NUM_CH         = 4,
    parameter int                ADDR_W         = 12,
    parameter logic [ADDR_W-1:0] BASE_ADDR      = 12'hF00,
    parameter int                CNT_W          = 24,
    parameter int                TRIG_CYCLES    = 500,
    parameter int                TIMEOUT_CYCLES = 1900000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    input  logic              we,
    output logic              hit,
    output logic [31:0]       rdata,
    output logic [NUM_CH-1:0] trig,
    input  logic [NUM_CH-1:0] echo,
    output logic              irq
);

    localparam int                IDX_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [ADDR_W:0]   LO_ADDR   = {1'b0, BASE_ADDR};
    localparam logic [ADDR_W:0]   HI_ADDR   = LO_ADDR + (ADDR_W+1)'(2 * NUM_CH);
    localparam logic [CNT_W-1:0]  TRIG_LAST = CNT_W'(TRIG_CYCLES - 1);
    localparam logic [CNT_W-1:0]  TOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_TRIG = 3'd1,
        S_WAIT = 3'd2,
        S_MEAS = 3'd3,
        S_DONE = 3'd4,
        S_TOUT = 3'd5
    } state_t;

    // Block base is aligned, so only the low address bits form the offset.
    logic [IDX_W:0]   offset;
    logic [IDX_W-1:0] ch_sel;
    logic             sel_result;
    logic             unused_wdata;

    assign hit          = ({1'b0, addr} >= LO_ADDR) && ({1'b0, addr} < HI_ADDR);
    assign offset       = addr[IDX_W:0] - BASE_ADDR[IDX_W:0];
    assign ch_sel       = offset[IDX_W:1];
    assign sel_result   = offset[0];
    assign unused_wdata = ^wdata[31:3];

    logic [NUM_CH-1:0] echo_meta_q;
    logic [NUM_CH-1:0] echo_s_q;
    logic [NUM_CH-1:0] irq_src;
    logic [4:0]        status_w [NUM_CH];
    logic [CNT_W-1:0]  result_w [NUM_CH];
    logic [31:0]       rdata_d;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        state_t           state_q, state_d;
        logic [CNT_W-1:0] timer_q, timer_d;
        logic [CNT_W-1:0] result_q, result_d;
        logic             ie_q, ie_d;
        logic             wr_ctrl;
        logic             busy, done, tout;

        assign wr_ctrl = we && hit && !sel_result && (ch_sel == IDX_W'(i));
        assign busy    = (state_q == S_TRIG) || (state_q == S_WAIT) || (state_q == S_MEAS);
        assign done    = (state_q == S_DONE);
        assign tout    = (state_q == S_TOUT);

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                state_q  <= S_IDLE;
                timer_q  <= '0;
                result_q <= '0;
                ie_q     <= 1'b0;
            end else begin
                state_q  <= state_d;
                timer_q  <= timer_d;
                result_q <= result_d;
                ie_q     <= ie_d;
            end
        end

        always_comb begin
            state_d  = state_q;
            timer_d  = timer_q;
            result_d = result_q;
            ie_d     = ie_q;
            case (state_q)
                S_TRIG: begin
                    if (timer_q == TRIG_LAST) begin
                        state_d = S_WAIT;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + CNT_ONE;
                    end
                end
                S_WAIT: begin
                    timer_d = timer_q + CNT_ONE;
                    if (timer_q == TOUT_LAST) begin
                        state_d = S_TOUT;
                    end else if (echo_s_q[i]) begin
                        state_d  = S_MEAS;
                        result_d = CNT_ONE;
                    end
                end
                S_MEAS: begin
                    timer_d = timer_q + CNT_ONE;
                    if (!echo_s_q[i]) begin
                        state_d = S_DONE;
                    end else begin
                        if (result_q != CNT_MAX) begin
                            result_d = result_q + CNT_ONE;
                        end
                        if (timer_q == TOUT_LAST) begin
                            state_d = S_TOUT;
                        end
                    end
                end
                default: ;
            endcase
            // Abort beats start; a start is only honoured when not busy.
            if (wr_ctrl) begin
                ie_d = wdata[2];
                if (wdata[1]) begin
                    state_d  = S_IDLE;
                    result_d = result_q;
                end else if (wdata[0] && !busy) begin
                    state_d  = S_TRIG;
                    timer_d  = '0;
                    result_d = '0;
                end
            end
        end

        assign trig[i]     = (state_q == S_TRIG);
        assign irq_src[i]  = ie_q && (done || tout);
        assign status_w[i] = {ie_q, tout, done, busy, trig[i]};
        assign result_w[i] = result_q;
    end

    always_comb begin
        rdata_d = '0;
        if (hit) begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (ch_sel == IDX_W'(k)) begin
                    rdata_d = sel_result ? 32'(result_w[k]) : {27'b0, status_w[k]};
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            echo_meta_q <= '0;
            echo_s_q    <= '0;
            rdata       <= '0;
            irq         <= 1'b0;
        end else begin
            echo_meta_q <= echo;
            echo_s_q    <= echo_meta_q;
            rdata       <= rdata_d;
            irq         <= |irq_src;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sonar_mmio_array.sv
`default_nettype none
// ============================================================================
// Module   : tb_sonar_mmio_array
// Brief    : Self-checking bench for sonar_mmio_array with a timeline model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sonar_mmio_array;

    localparam int NCH  = 4;
    localparam int AW   = 12;
    localparam int TRGC = 4;
    localparam int TOC  = 100;

    logic          clock = 1'b0;
    logic          reset;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic          we;
    logic          hit;
    logic [31:0]   rdata;
    logic [NCH-1:0] trig;
    logic [NCH-1:0] echo;
    logic          irq;

    sonar_mmio_array #(
        .NUM_CH(NCH), .ADDR_W(AW), .BASE_ADDR(12'hF00), .CNT_W(24),
        .TRIG_CYCLES(TRGC), .TIMEOUT_CYCLES(TOC)
    ) dut (
        .clock(clock), .reset(reset), .addr(addr), .wdata(wdata), .we(we),
        .hit(hit), .rdata(rdata), .trig(trig), .echo(echo), .irq(irq)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;
    bit m_ie   [NCH];
    bit m_flag [NCH];

    // Echo is seen two cycles late; window is TOC cycles from the end of trigger.
    function automatic void model(input int r, input int len, output bit tout, output int res);
        int ts;
        ts = r + 2;
        if (ts >= TOC - 1) begin
            tout = 1'b1; res = 0;
        end else if (ts + len <= TOC - 1) begin
            tout = 1'b0; res = len;
        end else begin
            tout = 1'b1; res = TOC - ts;
        end
    endfunction

    function automatic bit model_irq();
        bit v;
        v = 1'b0;
        for (int c = 0; c < NCH; c++) v = v | (m_ie[c] & m_flag[c]);
        return v;
    endfunction

    task automatic bus_write(input logic [AW-1:0] a, input logic [31:0] d);
        addr = a; wdata = d; we = 1'b1;
        @(posedge clock); #1;
        we = 1'b0; wdata = '0; addr = '0;
    endtask

    task automatic bus_read(input logic [AW-1:0] a, output logic [31:0] d);
        addr = a;
        @(posedge clock); #1;
        d = rdata;
        addr = '0;
    endtask

    // Starts a channel and returns once the trigger has fallen (first WAIT cycle).
    task automatic start_ch(input int ch, input bit ie, output int width, output int stray);
        logic [NCH-1:0] others;
        bus_write(AW'(12'hF00 + 2 * ch), {29'b0, ie, 2'b01});
        width = 0; stray = 0;
        while (trig[ch] && width < 20) begin
            width++;
            others = trig; others[ch] = 1'b0;
            if (others != '0) stray++;
            @(posedge clock); #1;
        end
    endtask

    task automatic drive_echo(input int ch, input int r, input int len);
        for (int k = 0; k < 110; k++) begin
            echo[ch] = (k >= r) && (k < r + len);
            @(posedge clock); #1;
        end
        echo[ch] = 1'b0;
        repeat (4) @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        checks++; if (trig !== '0) begin failures++; $display("FAIL reset_trig got=%0h exp=0", trig); end
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%0b exp=0", irq); end
        checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%0h exp=0", rdata); end
        for (int c = 0; c < NCH; c++) begin
            bus_read(AW'(12'hF00 + 2 * c), d);
            checks++; if (d !== 32'h0) begin failures++; $display("FAIL reset_status ch%0d got=%0h exp=0", c, d); end
        end
    endtask

    task automatic test_echo_pulse();
        int w, s; logic [31:0] d; bit tout; int res;
        start_ch(1, 1'b1, w, s);
        checks++; if (w != TRGC) begin failures++; $display("FAIL pulse_trig_width got=%0d exp=%0d", w, TRGC); end
        checks++; if (s != 0) begin failures++; $display("FAIL pulse_other_trig got=%0d exp=0", s); end
        drive_echo(1, 10, 37);
        model(10, 37, tout, res);
        m_ie[1] = 1'b1; m_flag[1] = 1'b1;
        bus_read(12'hF02, d);
        checks++; if (d !== {27'b0, 1'b1, tout, !tout, 2'b00}) begin
            failures++; $display("FAIL pulse_status got=%0h exp=%0h", d, {27'b0, 1'b1, tout, !tout, 2'b00}); end
        bus_read(12'hF03, d);
        checks++; if (d !== 32'(res)) begin failures++; $display("FAIL pulse_result got=%0d exp=%0d", d, res); end
        checks++; if (irq !== model_irq()) begin failures++; $display("FAIL pulse_irq got=%0b exp=%0b", irq, model_irq()); end
    endtask

    task automatic test_abort_retains();
        logic [31:0] d;
        bus_write(12'hF02, 32'h2);
        m_ie[1] = 1'b0; m_flag[1] = 1'b0;
        @(posedge clock); #1;
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL abort_irq got=%0b exp=0", irq); end
        bus_read(12'hF02, d);
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL abort_status got=%0h exp=0", d); end
        bus_read(12'hF03, d);
        checks++; if (d !== 32'd37) begin failures++; $display("FAIL abort_result_kept got=%0d exp=37", d); end
    endtask

    task automatic test_timeout();
        int w, s; logic [31:0] d;
        start_ch(0, 1'b0, w, s);
        checks++; if (w != TRGC) begin failures++; $display("FAIL tout_trig_width got=%0d exp=%0d", w, TRGC); end
        addr = 12'hF00;
        repeat (TOC) @(posedge clock);
        #1;
        checks++; if (rdata !== 32'h02) begin failures++; $display("FAIL tout_still_busy got=%0h exp=2", rdata); end
        @(posedge clock); #1;
        checks++; if (rdata !== 32'h08) begin failures++; $display("FAIL tout_status got=%0h exp=8", rdata); end
        addr = '0;
        m_flag[0] = 1'b1;
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL tout_irq got=%0b exp=0", irq); end
        bus_read(12'hF01, d);
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL tout_result got=%0d exp=0", d); end
    endtask

    task automatic test_partial_timeout();
        int w, s; logic [31:0] d; bit tout; int res;
        start_ch(2, 1'b0, w, s);
        checks++; if (w != TRGC) begin failures++; $display("FAIL partial_trig_width got=%0d exp=%0d", w, TRGC); end
        // Raw rise at 48 puts the synchronised rise 50 cycles into the window.
        drive_echo(2, 48, 60);
        model(48, 60, tout, res);
        m_flag[2] = 1'b1;
        bus_read(12'hF04, d);
        checks++; if (d !== {27'b0, 1'b0, tout, !tout, 2'b00}) begin
            failures++; $display("FAIL partial_status got=%0h exp=%0h", d, {27'b0, 1'b0, tout, !tout, 2'b00}); end
        bus_read(12'hF05, d);
        checks++; if (d !== 32'(res)) begin failures++; $display("FAIL partial_result got=%0d exp=%0d", d, res); end
    endtask

    task automatic test_busy_ignore();
        int width; logic [31:0] d;
        bus_write(12'hF06, 32'h1);
        addr = 12'hF06; wdata = 32'h1; we = 1'b1; width = 0;
        for (int k = 0; k < 10; k++) begin
            if (trig[3]) width++;
            @(posedge clock); #1;
            we = 1'b0; addr = '0; wdata = '0;
        end
        checks++; if (width != TRGC) begin failures++; $display("FAIL restart_ignored got=%0d exp=%0d", width, TRGC); end
        bus_write(12'hF06, 32'h3);
        checks++; if (trig[3] !== 1'b0) begin failures++; $display("FAIL abort_trig got=%0b exp=0", trig[3]); end
        bus_read(12'hF06, d);
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL abort_wait_status got=%0h exp=0", d); end
    endtask

    task automatic test_decode();
        addr = 12'hF03;
        @(posedge clock); #1;
        checks++; if (rdata !== 32'd37) begin failures++; $display("FAIL decode_prime got=%0d exp=37", rdata); end
        addr = 12'hF08; #1;
        checks++; if (hit !== 1'b0) begin failures++; $display("FAIL decode_hit_f08 got=%0b exp=0", hit); end
        @(posedge clock); #1;
        checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL decode_miss_rdata got=%0h exp=0", rdata); end
        addr = 12'hF03; #1;
        checks++; if (hit !== 1'b1) begin failures++; $display("FAIL decode_hit_f03 got=%0b exp=1", hit); end
        checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL decode_early got=%0h exp=0", rdata); end
        @(posedge clock); #1;
        checks++; if (rdata !== 32'd37) begin failures++; $display("FAIL decode_latency got=%0d exp=37", rdata); end
        addr = 12'hEFF; #1;
        checks++; if (hit !== 1'b0) begin failures++; $display("FAIL decode_hit_eff got=%0b exp=0", hit); end
        addr = 12'hF07; #1;
        checks++; if (hit !== 1'b1) begin failures++; $display("FAIL decode_hit_f07 got=%0b exp=1", hit); end
        addr = '0;
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        bus_write(12'hF04, 32'h4);
        m_ie[2] = 1'b1;
        @(posedge clock); #1;
        checks++; if (irq !== model_irq()) begin failures++; $display("FAIL ie_irq got=%0b exp=%0b", irq, model_irq()); end
        echo[1] = 1'b1;
        bus_write(12'hF02, 32'h5);
        @(posedge clock); #1;
        bus_write(12'hF06, 32'h1);
        @(posedge clock);
        @(posedge clock);
        @(posedge clock); #2;
        checks++; if (trig !== 4'b1000) begin failures++; $display("FAIL premid_trig got=%0b exp=1000", trig); end
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL premid_irq got=%0b exp=1", irq); end
        reset = 1'b1; #1;
        checks++; if (trig !== '0) begin failures++; $display("FAIL midreset_trig got=%0b exp=0", trig); end
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL midreset_irq got=%0b exp=0", irq); end
        echo = '0;
        @(posedge clock);
        @(posedge clock); #1;
        reset = 1'b0;
        for (int c = 0; c < NCH; c++) begin m_ie[c] = 1'b0; m_flag[c] = 1'b0; end
        for (int a = 0; a < 2 * NCH; a++) begin
            bus_read(AW'(12'hF00 + a), d);
            checks++; if (d !== 32'h0) begin failures++; $display("FAIL postreset_reg off%0d got=%0h exp=0", a, d); end
        end
        test_echo_pulse();
    endtask

    task automatic test_random();
        int ch, r, len, w, s, res; bit ie, tout; logic [31:0] d;
        for (int n = 0; n < 8; n++) begin
            ch  = $urandom_range(0, NCH - 1);
            ie  = 1'($urandom_range(0, 1));
            r   = $urandom_range(0, 105);
            len = $urandom_range(1, 110);
            start_ch(ch, ie, w, s);
            checks++; if (w != TRGC || s != 0) begin failures++; $display("FAIL rnd_trig ch%0d width=%0d stray=%0d exp=%0d/0", ch, w, s, TRGC); end
            drive_echo(ch, r, len);
            model(r, len, tout, res);
            m_ie[ch] = ie; m_flag[ch] = 1'b1;
            bus_read(AW'(12'hF00 + 2 * ch), d);
            checks++; if (d !== {27'b0, ie, tout, !tout, 2'b00}) begin
                failures++; $display("FAIL rnd_status ch%0d r=%0d len=%0d got=%0h exp=%0h", ch, r, len, d, {27'b0, ie, tout, !tout, 2'b00}); end
            bus_read(AW'(12'hF01 + 2 * ch), d);
            checks++; if (d !== 32'(res)) begin failures++; $display("FAIL rnd_result ch%0d r=%0d len=%0d got=%0d exp=%0d", ch, r, len, d, res); end
            checks++; if (irq !== model_irq()) begin failures++; $display("FAIL rnd_irq got=%0b exp=%0b", irq, model_irq()); end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; addr = '0; wdata = '0; we = 1'b0; echo = '0;
        for (int c = 0; c < NCH; c++) begin m_ie[c] = 1'b0; m_flag[c] = 1'b0; end
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        test_reset();
        test_echo_pulse();
        test_abort_retains();
        test_timeout();
        test_partial_timeout();
        test_busy_ignore();
        test_decode();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
